// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues req/addr and receives gnt/rvalid/rdata.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 11
);
  logic                  o_imem_req;
  logic [PC_WIDTH-1:0]   o_imem_addr;
  logic                  i_imem_gnt;
  logic                  i_imem_rvalid;
  logic [DATA_WIDTH-1:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, a one-entry
// buffer for responses that arrive while decode is stalled, and the IF/ID
// pipeline register. Redirects from execute cancel in-flight work; a response
// already granted before the redirect is marked for discard.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 11,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall_d,
  input  logic                  i_flush_d,
  input  logic                  i_pcsrc_e,
  input  logic [PC_WIDTH-1:0]   i_pctarget_e,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] o_instr_d,
  output logic [PC_WIDTH-1:0]   o_pc_d,
  output logic [PC_WIDTH-1:0]   o_pc4_d,
  output logic                  o_fetch_busy
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding until granted
    S_WAIT = 2'd1,  // granted, waiting for rvalid
    S_HOLD = 2'd2   // response buffered, decode stalled
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_f_q, pc_f_d;
  logic [PC_WIDTH-1:0]   pc_req_q, pc_req_d;
  logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [PC_WIDTH-1:0]   ifid_pc4_q, ifid_pc4_d;
  logic                  req_q, busy_q;

  logic [PC_WIDTH-1:0]   pc_seq;
  logic [PC_WIDTH-1:0]   redirect_pc;

  // Sequential successor of the granted fetch; wraps modulo 2^PC_WIDTH.
  assign pc_seq      = pc_req_q + PC_STEP;
  // Redirect targets are forced to word alignment.
  assign redirect_pc = i_pctarget_e & ~PC_WIDTH'(3);

  // Next-state, buffer and IF/ID selection; redirect beats flush beats stall.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_req_d     = pc_req_q;
    buf_instr_d  = buf_instr_q;
    discard_d    = discard_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;

    if (i_pcsrc_e) begin
      pc_f_d       = redirect_pc;
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      buf_instr_d  = '0;
      // A fetch granted but not yet answered must have its response dropped.
      if ((state_q == S_WAIT && !imem.i_imem_rvalid) ||
          (state_q == S_REQ && imem.i_imem_gnt)) begin
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    end else begin
      // Default IF/ID behaviour when nothing is delivered: bubble unless held.
      if (i_flush_d || !i_stall_d) begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = '0;
        ifid_pc4_d   = '0;
      end
      case (state_q)
        S_REQ: begin
          if (imem.i_imem_gnt) begin
            pc_req_d = pc_f_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.i_imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (i_flush_d || i_stall_d) begin
              // Decode cannot take it now; park it until released.
              buf_instr_d = imem.i_imem_rdata;
              state_d     = S_HOLD;
            end else begin
              ifid_instr_d = imem.i_imem_rdata;
              ifid_pc_d    = pc_req_q;
              ifid_pc4_d   = pc_seq;
              pc_f_d       = pc_seq;
              state_d      = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!i_flush_d && !i_stall_d) begin
            ifid_instr_d = buf_instr_q;
            ifid_pc_d    = pc_req_q;
            ifid_pc4_d   = pc_seq;
            pc_f_d       = pc_seq;
            state_d      = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // State, datapath and registered request/busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_REQ;
      pc_f_q       <= '0;
      pc_req_q     <= '0;
      buf_instr_q  <= '0;
      discard_q    <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      req_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_req_q     <= pc_req_d;
      buf_instr_q  <= buf_instr_d;
      discard_q    <= discard_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      req_q        <= (state_d == S_REQ);
      busy_q       <= (state_d != S_REQ);
    end
  end

  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc_f_q;
  assign o_instr_d        = ifid_instr_q;
  assign o_pc_d           = ifid_pc_q;
  assign o_pc4_d          = ifid_pc4_q;
  assign o_fetch_busy     = busy_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/data word width.
REQ-002 Parameter PC_WIDTH, default 11, byte-address PC width.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_stall_d  in  1  IF/ID register must hold (decode stalled).
REQ-007 i_flush_d  in  1  IF/ID register loads bubble.
REQ-008 i_pcsrc_e  in  1  redirect request from execute.
REQ-009 i_pctarget_e  in  PC_WIDTH  redirect target.
REQ-010 o_imem_req  out  1  instruction fetch request.
REQ-011 o_imem_addr  out  PC_WIDTH  fetch byte address.
REQ-012 i_imem_gnt  in  1  request accepted this cycle.
REQ-013 i_imem_rvalid  in  1  response data valid.
REQ-014 i_imem_rdata  in  DATA_WIDTH  response instruction.
REQ-015 o_instr_d, o_pc_d, o_pc4_d  out  DATA_WIDTH/PC_WIDTH/PC_WIDTH  IF/ID register outputs to decode.
REQ-016 o_fetch_busy  out  1  high in every state except REQ; for hazard/debug visibility.

Function
REQ-017 State machine SHALL have states REQ (request outstanding until grant), WAIT (granted, awaiting rvalid), HOLD (instruction buffered, decode stalled).
REQ-018 Internal regs: pc_f (next fetch address), pc_req (address of granted fetch), buf_instr, discard flag.
REQ-019 REQ: o_imem_req=1, o_imem_addr=pc_f, both held stable until i_imem_gnt; on gnt pc_req<=pc_f, go WAIT.
REQ-020 o_imem_req SHALL be 0 in WAIT and HOLD; at most one fetch outstanding.
REQ-021 WAIT, rvalid, discard=0, i_stall_d=0: IF/ID <= {rdata, pc_req, pc_req+4}; pc_f<=pc_req+4; go REQ.
REQ-022 WAIT, rvalid, discard=0, i_stall_d=1: buf_instr<=rdata; go HOLD; IF/ID unchanged.
REQ-023 HOLD with i_stall_d=0: IF/ID <= {buf_instr, pc_req, pc_req+4}; pc_f<=pc_req+4; go REQ.
REQ-024 Any cycle i_stall_d=0 with no instruction delivered: IF/ID <= {NOP_INSTR, 0, 0} (bubble).
REQ-025 i_stall_d=1 and i_flush_d=0: IF/ID holds value.
REQ-026 i_flush_d=1: IF/ID <= {NOP_INSTR, 0, 0} regardless of i_stall_d; any instruction delivered same cycle is lost only if redirect also set (REQ-027), else it goes to buffer/HOLD.
REQ-027 i_pcsrc_e=1: pc_f<={i_pctarget_e[PC_WIDTH-1:2],2'b00}; IF/ID loads bubble; buffer dropped; state goes REQ, except WAIT without rvalid or REQ with gnt -> WAIT with discard<=1.
REQ-028 WAIT, rvalid with discard=1: response dropped, discard<=0, go REQ (pc_f already redirected).
REQ-029 Priority: i_rst > i_pcsrc_e > i_flush_d > i_stall_d.
REQ-030 PC arithmetic modulo 2^PC_WIDTH; pc 0x7FC +4 wraps to 0x000; o_pc4_d likewise.
REQ-031 Redirect in REQ without gnt: o_imem_addr switches to new target next cycle (address change allowed only on redirect).

Reset
REQ-032 i_rst=1 at a clock edge: state<=REQ, pc_f<=0, pc_req<=0, discard<=0, buf_instr<=0, o_instr_d<=NOP_INSTR, o_pc_d<=0, o_pc4_d<=0.
REQ-033 Reset mid-transaction abandons outstanding fetch; environment SHALL not return its rvalid after reset; first post-reset request (addr 0) issued cycle after reset deasserts.

Verification
REQ-034 Zero-wait memory (gnt same cycle, rvalid next), instrs A@0,B@4: IF/ID shows A/pc 0/pc4 4, then bubble, then B/pc 4/pc4 8.
REQ-035 rvalid arrives while i_stall_d=1 for 3 cycles: state HOLD, IF/ID unchanged, no new request; on release IF/ID=buffered instr, next req addr = pc_req+4.
REQ-036 Redirect to 0x100 while WAIT for fetch @0x20: late response discarded, never in IF/ID; next request addr 0x100.
REQ-037 Redirect and rvalid same cycle: response dropped, IF/ID=NOP, next req addr = target; target 0x103 fetched as 0x100.
REQ-038 pc_req=0x7FC delivered: o_pc4_d=0x000, next request addr 0x000.
REQ-039 i_rst asserted in WAIT: next cycle o_instr_d=0x00000013, o_pc_d=0, o_imem_req=1 with addr 0.
